// File: rtl/rect_fill_engine.sv
// Rectangle-fill accelerator: queues {x0,y0,x1,y1,color} commands and streams
// one VRAM pixel write per accepted cycle, row-major, clipped to the screen.
module rect_fill_engine #(
  parameter int COORD_W    = 8,
  parameter int COLOR_W    = 3,
  parameter int VRAM_W     = 80,
  parameter int VRAM_H     = 60,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iCmdValid,
  output logic               oCmdReady,
  input  logic [COORD_W-1:0] iX0,
  input  logic [COORD_W-1:0] iY0,
  input  logic [COORD_W-1:0] iX1,
  input  logic [COORD_W-1:0] iY1,
  input  logic [COLOR_W-1:0] iColor,
  output logic               oVramWe,
  output logic [ADDR_W-1:0]  oVramAddr,
  output logic [COLOR_W-1:0] oVramData,
  input  logic               iVramReady,
  output logic               oBusy,
  output logic               oDone
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = 4 * COORD_W + COLOR_W;
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(VRAM_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(VRAM_H - 1);
  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(VRAM_W);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                push, pop;

  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [COORD_W-1:0]  xl_q, xl_d, xh_q, xh_d, yh_q, yh_d, x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]   rowbase_q, rowbase_d;
  logic [COLOR_W-1:0]  color_q, color_d;

  logic                we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOR_W-1:0]  data_q, data_d;

  logic [COORD_W-1:0]  cx0, cy0, cx1, cy1;
  logic [COLOR_W-1:0]  ccol;
  logic [COORD_W-1:0]  nxl, nxh, nyl, nyh, cxh, cyh;
  logic                off_screen;

  assign cx0  = cmd_q[CMD_W-1 -: COORD_W];
  assign cy0  = cmd_q[CMD_W-1-COORD_W -: COORD_W];
  assign cx1  = cmd_q[CMD_W-1-2*COORD_W -: COORD_W];
  assign cy1  = cmd_q[CMD_W-1-3*COORD_W -: COORD_W];
  assign ccol = cmd_q[COLOR_W-1:0];

  // Corner normalisation and clipping feed the LOAD state
  assign nxl = (cx0 < cx1) ? cx0 : cx1;
  assign nxh = (cx0 < cx1) ? cx1 : cx0;
  assign nyl = (cy0 < cy1) ? cy0 : cy1;
  assign nyh = (cy0 < cy1) ? cy1 : cy0;
  assign cxh = (nxh > X_MAX) ? X_MAX : nxh;
  assign cyh = (nyh > Y_MAX) ? Y_MAX : nyh;
  assign off_screen = (nxl > X_MAX) || (nyl > Y_MAX);

  assign push = iCmdValid & ready_q;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    cmd_d     = cmd_q;
    xl_d      = xl_q;
    xh_d      = xh_q;
    yh_d      = yh_q;
    x_d       = x_q;
    y_d       = y_q;
    rowbase_d = rowbase_q;
    color_d   = color_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (count_q != '0) begin
          pop     = 1'b1;
          cmd_d   = fifo_mem[rd_ptr_q];
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (off_screen) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          xl_d      = nxl;
          xh_d      = cxh;
          yh_d      = cyh;
          x_d       = nxl;
          y_d       = nyl;
          rowbase_d = ADDR_W'(nyl) * ROW_STEP;
          color_d   = ccol;
          state_d   = FILL;
        end
      end
      FILL: begin
        // x_q/y_q always name the pixel currently on the bus; advance only on accept
        if (!we_q) begin
          we_d   = 1'b1;
          addr_d = rowbase_q + ADDR_W'(x_q);
          data_d = color_q;
        end else if (iVramReady) begin
          if (x_q < xh_q) begin
            x_d    = x_q + COORD_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else if (y_q < yh_q) begin
            x_d       = xl_q;
            y_d       = y_q + COORD_W'(1);
            rowbase_d = rowbase_q + ROW_STEP;
            addr_d    = rowbase_q + ROW_STEP + ADDR_W'(xl_q);
          end else begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  // Payload registers carry no control meaning, so they skip reset
  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {iX0, iY0, iX1, iY1, iColor};
    cmd_q     <= cmd_d;
    xl_q      <= xl_d;
    xh_q      <= xh_d;
    yh_q      <= yh_d;
    x_q       <= x_d;
    y_q       <= y_d;
    rowbase_q <= rowbase_d;
    color_q   <= color_d;
  end

  assign oCmdReady = ready_q;
  assign oVramWe   = we_q;
  assign oVramAddr = addr_q;
  assign oVramData = data_q;
  assign oDone     = done_q;
  assign oBusy     = (count_q != '0) || (state_q != IDLE);

endmodule
